// File: rtl/pe_sched_pkg.sv
// Shared types and helpers for the PE convolution scheduler.
package pe_sched_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH_W,
      S_WAIT_WLOAD,
      S_FETCH_A,
      S_WAIT_ALOAD,
      S_START_PE,
      S_WAIT_PE,
      S_EMIT,
      S_FINISH
   } sched_state_e;

   typedef enum logic {
      PH_WEIGHT,
      PH_ACTIVATION
   } phase_e;

   function automatic int num_windows(input int act_size, input int kern_size, input int stride);
      return (act_size - kern_size) / stride + 1;
   endfunction

endpackage

// File: rtl/pe_watchdog.sv
// Wait-state watchdog: counts while enabled, expire pulses on the last allowed cycle.
module pe_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en)  r_cnt <= r_cnt + CW'(1);
   end

   // Fires in the cycle that would complete TIMEOUT_CYCLES of waiting.
   assign o_expire = i_en && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pe_conv_scheduler.sv
// Runs one PE through a 1-D convolution job: load weights once, then per window
// load activations, start the PE, and hand the result downstream.
module pe_conv_scheduler
   import pe_sched_pkg::*;
#(
   parameter int DATA_WIDTH      = 16,
   parameter int ADDR_WIDTH      = 9,
   parameter int KERNEL_SIZE     = 3,
   parameter int ACTIVATION_SIZE = 5,
   parameter int STRIDE          = 1,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  job_start,
   input  logic [ADDR_WIDTH-1:0] weight_base,
   input  logic [ADDR_WIDTH-1:0] act_base,
   output logic                  job_busy,
   output logic                  job_done,
   output logic                  job_error,
   output logic                  buf_rd_en,
   output logic [ADDR_WIDTH-1:0] buf_rd_addr,
   input  logic [DATA_WIDTH-1:0] buf_rd_data,
   output logic [DATA_WIDTH-1:0] pe_filter_data,
   output logic [DATA_WIDTH-1:0] pe_activation_data,
   output logic                  pe_load_enable_weight,
   output logic                  pe_load_enable_activation,
   output logic                  pe_start,
   input  logic                  pe_load_done,
   input  logic                  pe_compute_done,
   input  logic [DATA_WIDTH-1:0] pe_out,
   output logic                  res_valid,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic [7:0]            res_index,
   input  logic                  res_ready
);
   localparam int NW = num_windows(ACTIVATION_SIZE, KERNEL_SIZE, STRIDE);
   localparam int KW = $clog2(KERNEL_SIZE + 1);

   sched_state_e          r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_wbase;
   logic [ADDR_WIDTH-1:0] r_wptr;     // activation base of the current window
   logic [KW-1:0]         r_idx;
   logic [7:0]            r_win;
   logic                  r_err;
   logic                  r_ld_en;
   phase_e                r_ld_phase;
   logic [DATA_WIDTH-1:0] r_res;

   logic w_wait, w_expire, w_to_error, w_fetch_last, w_last_win;

   assign w_wait       = (r_state == S_WAIT_WLOAD) || (r_state == S_WAIT_ALOAD) || (r_state == S_WAIT_PE);
   assign w_fetch_last = (r_idx == KW'(KERNEL_SIZE - 1));
   assign w_last_win   = (r_win == 8'(NW - 1));

   pe_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk      (clk),
      .reset    (reset),
      .i_clr    (!w_wait),
      .i_en     (w_wait),
      .o_expire (w_expire)
   );

   assign job_busy                  = (r_state != S_IDLE);
   assign job_error                 = r_err;
   assign pe_filter_data            = buf_rd_data;
   assign pe_activation_data        = buf_rd_data;
   assign pe_load_enable_weight     = r_ld_en && (r_ld_phase == PH_WEIGHT);
   assign pe_load_enable_activation = r_ld_en && (r_ld_phase == PH_ACTIVATION);
   assign res_data                  = r_res;
   assign res_index                 = r_win;

   always_comb begin
      w_next      = r_state;
      w_to_error  = 1'b0;
      buf_rd_en   = 1'b0;
      buf_rd_addr = '0;
      pe_start    = 1'b0;
      res_valid   = 1'b0;
      job_done    = 1'b0;
      case (r_state)
         S_IDLE:       if (job_start) w_next = S_FETCH_W;
         S_FETCH_W: begin
            buf_rd_en   = 1'b1;
            buf_rd_addr = r_wbase + ADDR_WIDTH'(r_idx);
            if (w_fetch_last) w_next = S_WAIT_WLOAD;
         end
         // The awaited input takes priority over a coincident expiry.
         S_WAIT_WLOAD: if (pe_load_done) w_next = S_FETCH_A;
                       else if (w_expire) begin w_next = S_FINISH; w_to_error = 1'b1; end
         S_FETCH_A: begin
            buf_rd_en   = 1'b1;
            buf_rd_addr = r_wptr + ADDR_WIDTH'(r_idx);
            if (w_fetch_last) w_next = S_WAIT_ALOAD;
         end
         S_WAIT_ALOAD: if (pe_load_done) w_next = S_START_PE;
                       else if (w_expire) begin w_next = S_FINISH; w_to_error = 1'b1; end
         S_START_PE: begin
            pe_start = 1'b1;
            w_next   = S_WAIT_PE;
         end
         S_WAIT_PE:    if (pe_compute_done) w_next = S_EMIT;
                       else if (w_expire) begin w_next = S_FINISH; w_to_error = 1'b1; end
         S_EMIT: begin
            res_valid = 1'b1;
            if (res_ready) w_next = w_last_win ? S_FINISH : S_FETCH_A;
         end
         S_FINISH: begin
            job_done = 1'b1;
            w_next   = S_IDLE;
         end
         default:      w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_wbase    <= '0;
         r_wptr     <= '0;
         r_idx      <= '0;
         r_win      <= '0;
         r_err      <= 1'b0;
         r_ld_en    <= 1'b0;
         r_ld_phase <= PH_WEIGHT;
         r_res      <= '0;
      end else begin
         r_state    <= w_next;
         r_ld_en    <= buf_rd_en;
         r_ld_phase <= (r_state == S_FETCH_W) ? PH_WEIGHT : PH_ACTIVATION;
         if (w_to_error) r_err <= 1'b1;
         case (r_state)
            S_IDLE: if (job_start) begin
               r_wbase <= weight_base;
               r_wptr  <= act_base;
               r_err   <= 1'b0;
               r_win   <= '0;
               r_idx   <= '0;
            end
            S_FETCH_W, S_FETCH_A: r_idx <= w_fetch_last ? '0 : r_idx + KW'(1);
            S_WAIT_PE: if (pe_compute_done) r_res <= pe_out;
            S_EMIT: if (res_ready && !w_last_win) begin
               r_win  <= r_win + 8'd1;
               r_wptr <= r_wptr + ADDR_WIDTH'(STRIDE);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_conv_scheduler.sv
// Scoreboard bench for pe_conv_scheduler with a buffer model and a small PE model.
module tb_pe_conv_scheduler;
   localparam int DW = 16;
   localparam int AW = 9;
   localparam int K  = 3;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          job_start = 1'b0;
   logic [AW-1:0] weight_base = '0, act_base = '0;
   logic          job_busy, job_done, job_error, buf_rd_en;
   logic [AW-1:0] buf_rd_addr;
   logic [DW-1:0] buf_rd_data = '0;
   logic [DW-1:0] pe_filter_data, pe_activation_data, pe_out, res_data;
   logic          pe_load_enable_weight, pe_load_enable_activation, pe_start;
   logic          pe_load_done, pe_compute_done, res_valid;
   logic          res_ready = 1'b1;
   logic [7:0]    res_index;

   pe_conv_scheduler #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .KERNEL_SIZE(K),
      .ACTIVATION_SIZE(5), .STRIDE(1), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .job_start(job_start),
      .weight_base(weight_base), .act_base(act_base),
      .job_busy(job_busy), .job_done(job_done), .job_error(job_error),
      .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
      .pe_filter_data(pe_filter_data), .pe_activation_data(pe_activation_data),
      .pe_load_enable_weight(pe_load_enable_weight),
      .pe_load_enable_activation(pe_load_enable_activation),
      .pe_start(pe_start), .pe_load_done(pe_load_done),
      .pe_compute_done(pe_compute_done), .pe_out(pe_out),
      .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
      .res_ready(res_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Buffer: word at address a holds a+1, one-cycle read latency.
   always @(posedge clk) if (buf_rd_en) buf_rd_data <= DW'(buf_rd_addr) + 16'd1;

   // PE: load_done the cycle after the last load, compute_done 4 cycles after start.
   logic [DW-1:0] wreg [K];
   logic [DW-1:0] areg [K];
   int  wi, ai, cd;
   bit  pe_hang = 1'b0;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         wi <= 0; ai <= 0; cd <= 0; pe_load_done <= 1'b0;
      end else begin
         pe_load_done <= 1'b0;
         if (pe_load_enable_weight) begin
            wreg[wi] <= pe_filter_data;
            if (wi == K-1) begin wi <= 0; pe_load_done <= 1'b1; end else wi <= wi + 1;
         end
         if (pe_load_enable_activation) begin
            areg[ai] <= pe_activation_data;
            if (ai == K-1) begin ai <= 0; pe_load_done <= 1'b1; end else ai <= ai + 1;
         end
         if (pe_start) cd <= 4; else if (cd > 0) cd <= cd - 1;
      end
   end
   assign pe_compute_done = (cd == 1) && !pe_hang;
   always_comb begin
      pe_out = '0;
      for (int i = 0; i < K; i++) pe_out += wreg[i] * areg[i];
   end

   typedef struct packed { logic [DW-1:0] d; logic [7:0] i; } res_t;
   logic [AW-1:0] q_addr[$];
   res_t          q_res[$];
   bit            q_done[$];
   int checks = 0, failures = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++; failures++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // Monitor: every read, transfer and done is matched against the queues.
   always @(negedge clk) if (reset) begin
      if (buf_rd_en) begin
         if (q_addr.size() == 0) fail_now("rd_addr_unexpected");
         else chk("rd_addr", buf_rd_addr, q_addr.pop_front());
      end
      if (res_valid && res_ready) begin
         if (q_res.size() == 0) fail_now("res_unexpected");
         else begin
            res_t e;
            e = q_res.pop_front();
            chk("res_data", res_data, e.d);
            chk("res_index", res_index, e.i);
         end
      end
      if (job_done) begin
         if (q_done.size() == 0) fail_now("job_done_unexpected");
         else chk("job_done_error", job_error, q_done.pop_front());
      end
   end

   task automatic push_addrs(input int a[]);
      foreach (a[i]) q_addr.push_back(AW'(a[i]));
   endtask

   task automatic push_res(input int d0, input int d1, input int d2);
      q_res.push_back('{d: DW'(d0), i: 8'd0});
      q_res.push_back('{d: DW'(d1), i: 8'd1});
      q_res.push_back('{d: DW'(d2), i: 8'd2});
   endtask

   task automatic start_job(input int wb, input int ab);
      @(posedge clk); #1;
      weight_base = AW'(wb); act_base = AW'(ab); job_start = 1'b1;
      @(posedge clk); #1;
      job_start = 1'b0;
      chk("busy_after_accept", job_busy, 1);
      chk("first_rd_en", buf_rd_en, 1);
   endtask

   task automatic wait_done(input string name, input int maxc);
      int n = 0;
      while (!job_done && n < maxc) begin @(posedge clk); #1; n++; end
      if (!job_done) fail_now(name);
   endtask

   task automatic wait_pe_start(input string name);
      int n = 0;
      while (!pe_start && n < 200) begin @(posedge clk); #1; n++; end
      if (!pe_start) fail_now(name);
   endtask

   task automatic wait_res_valid(input string name);
      int n = 0;
      while (!res_valid && n < 200) begin @(posedge clk); #1; n++; end
      if (!res_valid) fail_now(name);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_busy"}, job_busy, 0);
      chk({tag, "_done"}, job_done, 0);
      chk({tag, "_error"}, job_error, 0);
      chk({tag, "_rd_en"}, buf_rd_en, 0);
      chk({tag, "_rd_addr"}, buf_rd_addr, 0);
      chk({tag, "_ldw"}, pe_load_enable_weight, 0);
      chk({tag, "_lda"}, pe_load_enable_activation, 0);
      chk({tag, "_pe_start"}, pe_start, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_res_data"}, res_data, 0);
      chk({tag, "_res_index"}, res_index, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation bound reached");
      $fatal(1, "global timeout");
   end

   initial begin
      int s, d;
      logic [DW-1:0] hold_d;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      reset = 1'b1;

      // Basic job: weights 1,2,3 against activations 101..105.
      push_addrs('{0,1,2, 100,101,102, 101,102,103, 102,103,104});
      push_res(614, 620, 626);
      q_done.push_back(1'b0);
      start_job(0, 100);
      wait_done("t1_done", 300);
      @(posedge clk); #1;
      chk("t1_idle", job_busy, 0);
      chk("t1_reads_left", q_addr.size(), 0);
      chk("t1_res_left", q_res.size(), 0);

      // Backpressure on window 1 for 10 cycles.
      push_addrs('{0,1,2, 100,101,102, 101,102,103, 102,103,104});
      push_res(614, 620, 626);
      q_done.push_back(1'b0);
      start_job(0, 100);
      wait_res_valid("t2_valid0");
      @(posedge clk); #1;
      res_ready = 1'b0;
      wait_res_valid("t2_valid1");
      chk("t2_stall_index", res_index, 1);
      hold_d = res_data;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("t2_stall_valid", res_valid, 1);
         chk("t2_stall_index_hold", res_index, 1);
         chk("t2_stall_data_hold", res_data, hold_d);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("t2_valid_drop", res_valid, 0);
      chk("t2_fetch_a_next", buf_rd_en, 1);
      wait_done("t2_done", 300);
      @(posedge clk); #1;
      chk("t2_res_left", q_res.size(), 0);

      // PE never completes: watchdog error.
      pe_hang = 1'b1;
      push_addrs('{0,1,2, 100,101,102});
      q_done.push_back(1'b1);
      start_job(0, 100);
      wait_pe_start("t3_pe_start");
      s = cyc;
      wait_done("t3_done", 100);
      d = cyc;
      chk("t3_wd_latency", d - s, 17);
      chk("t3_error", job_error, 1);
      @(posedge clk); #1;
      chk("t3_error_sticky", job_error, 1);
      chk("t3_idle", job_busy, 0);
      pe_hang = 1'b0;

      // Address wrap at the top of the buffer; also clears the sticky error.
      push_addrs('{5,6,7, 510,511,0, 511,0,1, 0,1,2});
      push_res(6658, 3095, 44);
      q_done.push_back(1'b0);
      start_job(5, 510);
      chk("t4_error_cleared", job_error, 0);
      wait_done("t4_done", 300);
      @(posedge clk); #1;
      chk("t4_res_left", q_res.size(), 0);

      // Asynchronous reset during WAIT_PE.
      push_addrs('{0,1,2, 100,101,102});
      start_job(0, 100);
      wait_pe_start("t5_pe_start");
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 reset = 1'b0;
      #1 check_outputs_zero("t5_async");
      @(posedge clk); #1;
      reset = 1'b1;
      chk("t5_reads_left", q_addr.size(), 0);

      // Stray job_start during FETCH_A and coincident with job_done.
      push_addrs('{0,1,2, 200,201,202, 201,202,203, 202,203,204});
      push_res(1214, 1220, 1226);
      q_done.push_back(1'b0);
      start_job(0, 200);
      begin
         int n = 0;
         while (!(buf_rd_en && buf_rd_addr == 9'd200) && n < 100) begin @(posedge clk); #1; n++; end
         if (!(buf_rd_en && buf_rd_addr == 9'd200)) fail_now("t6_fetch_a");
      end
      weight_base = 9'd50; act_base = 9'd300; job_start = 1'b1;
      @(posedge clk); #1;
      job_start = 1'b0;
      wait_done("t6_done", 300);
      job_start = 1'b1;
      @(posedge clk); #1;
      job_start = 1'b0;
      chk("t6_ignored_at_done", job_busy, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("t6_still_idle", job_busy, 0);
      chk("t6_no_reads", buf_rd_en, 0);
      chk("t6_error", job_error, 0);
      chk("t6_reads_left", q_addr.size(), 0);
      chk("t6_res_left", q_res.size(), 0);
      chk("t6_done_left", q_done.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
